stage4: RTL and testbench

STAGE4 -- requirements
Module: stage4

---
 rtl/stage4.sv | 188 ++++++++++++++++++
 tb/tb_stage4.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4.sv
// stage4 -- memory/writeback pipeline stage with a self-clearing 256 x 32 data memory.
//
// After every reset the stage runs a 256-cycle CLEAR pass that zeroes the whole
// data memory while holding busy high; it then enters RUN and processes one
// instruction per enabled cycle with a single register of latency.
//
// Optional feature: define STAGE4_PERF_CNT_EN to build the saturating load/store
// performance counters. When it is undefined, load_count and store_count are
// tied to zero and no counter logic exists.
module stage4 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             control,
    input  logic [31:0]      ALU_Result,
    input  logic             X_in,
    input  logic [3:0]       D,
    input  logic [7:0]       address,
    input  logic             RegWrite,
    input  logic             RegInsrc,
    input  logic             DataRead,
    input  logic             DataWrite,
    input  logic             JumpSrc,
    output logic [31:0]      WB_Data_out,
    output logic [3:0]       D_out,
    output logic             RegWrite_out,
    output logic             jump_taken,
    output logic [7:0]       jump_target,
    output logic             busy,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [7:0] clr_ptr_q, clr_ptr_d;

    logic [31:0] mem [0:255];

    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // An instruction is accepted only in RUN with the stage enabled.
    logic run_active;

    logic [31:0] wb_data_q, wb_data_d;
    logic [3:0]  d_out_q, d_out_d;
    logic        reg_write_q, reg_write_d;
    logic        jump_taken_q, jump_taken_d;
    logic [7:0]  jump_target_q, jump_target_d;

    assign run_active = (state_q == RUN) && control;
    assign busy       = (state_q == CLEAR);

    // Combinational read returns the pre-write contents when a load and store
    // hit the same address in one cycle.
    assign mem_rdata = mem[address];

    // Next-state logic: sweep clr_ptr through every word, then enter RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 8'd1;
            if (clr_ptr_q == 8'hFF) begin
                state_d = RUN;
            end
        end
    end

    // State register; reset always restarts the clear pass at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Memory write port select: the clear sweep owns the port during CLEAR,
    // stores own it during RUN. Nothing is written in a reset cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = ALU_Result;
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = 32'd0;
            end else if (control && DataWrite) begin
                mem_we    = 1'b1;
                mem_waddr = address;
                mem_wdata = ALU_Result;
            end
        end
    end

    // Data memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next values of the writeback/jump output registers; hold unless accepting.
    always_comb begin
        wb_data_d     = wb_data_q;
        d_out_d       = d_out_q;
        reg_write_d   = reg_write_q;
        jump_taken_d  = jump_taken_q;
        jump_target_d = jump_target_q;
        if (run_active) begin
            wb_data_d     = (DataRead && RegInsrc) ? mem_rdata : ALU_Result;
            d_out_d       = D;
            reg_write_d   = RegWrite;
            jump_taken_d  = JumpSrc && X_in;
            jump_target_d = address;
        end
    end

    // Output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_q     <= 32'd0;
            d_out_q       <= 4'd0;
            reg_write_q   <= 1'b0;
            jump_taken_q  <= 1'b0;
            jump_target_q <= 8'd0;
        end else begin
            wb_data_q     <= wb_data_d;
            d_out_q       <= d_out_d;
            reg_write_q   <= reg_write_d;
            jump_taken_q  <= jump_taken_d;
            jump_target_q <= jump_target_d;
        end
    end

    assign WB_Data_out  = wb_data_q;
    assign D_out        = d_out_q;
    assign RegWrite_out = reg_write_q;
    assign jump_taken   = jump_taken_q;
    assign jump_target  = jump_target_q;

`ifdef STAGE4_PERF_CNT_EN
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;

    // Saturating counters of accepted loads and stores.
    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        if (run_active && DataRead && (load_count_q != {CNT_W{1'b1}})) begin
            load_count_d = load_count_q + 1'b1;
        end
        if (run_active && DataWrite && (store_count_q != {CNT_W{1'b1}})) begin
            store_count_d = store_count_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
        end
    end

    assign load_count  = load_count_q;
    assign store_count = store_count_q;
`else
    assign load_count  = '0;
    assign store_count = '0;
`endif

endmodule

// File: tb/tb_stage4.sv
// Directed testbench for stage4, built with CNT_W = 4 so counter saturation is
// reachable quickly. Expected counter values follow STAGE4_PERF_CNT_EN.
module tb_stage4;

    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                reset;
    logic                control;
    logic [31:0]         ALU_Result;
    logic                X_in;
    logic [3:0]          D;
    logic [7:0]          address;
    logic                RegWrite;
    logic                RegInsrc;
    logic                DataRead;
    logic                DataWrite;
    logic                JumpSrc;
    logic [31:0]         WB_Data_out;
    logic [3:0]          D_out;
    logic                RegWrite_out;
    logic                jump_taken;
    logic [7:0]          jump_target;
    logic                busy;
    logic [TB_CNT_W-1:0] load_count;
    logic [TB_CNT_W-1:0] store_count;

    int errors;
    int checks;

    stage4 #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .control      (control),
        .ALU_Result   (ALU_Result),
        .X_in         (X_in),
        .D            (D),
        .address      (address),
        .RegWrite     (RegWrite),
        .RegInsrc     (RegInsrc),
        .DataRead     (DataRead),
        .DataWrite    (DataWrite),
        .JumpSrc      (JumpSrc),
        .WB_Data_out  (WB_Data_out),
        .D_out        (D_out),
        .RegWrite_out (RegWrite_out),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .busy         (busy),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter value: saturating count when the counters are built, else 0.
    function automatic logic [TB_CNT_W-1:0] cexp(input int n);
`ifdef STAGE4_PERF_CNT_EN
        if (n > 15) return 4'hF;
        return n[TB_CNT_W-1:0];
`else
        return '0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ctl, input logic [31:0] alu, input logic x,
                         input logic [3:0] d, input logic [7:0] addr,
                         input logic rw, input logic rin, input logic dr,
                         input logic dw, input logic js);
        control    = ctl;
        ALU_Result = alu;
        X_in       = x;
        D          = d;
        address    = addr;
        RegWrite   = rw;
        RegInsrc   = rin;
        DataRead   = dr;
        DataWrite  = dw;
        JumpSrc    = js;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Counts cycles until busy drops (bounded), then idles the inputs at once.
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            cycle();
            n++;
        end
        idle();
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 256", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        cycle();
        reset = 1'b0;
        checks++;
        if ({busy, WB_Data_out, D_out, RegWrite_out, jump_taken, jump_target} !== {1'b1, 32'd0, 4'd0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b wb=%h d=%h rw=%b jt=%b tgt=%h expected busy=1 rest 0",
                     busy, WB_Data_out, D_out, RegWrite_out, jump_taken, jump_target);
        end
        checks++;
        if (load_count !== 4'h0 || store_count !== 4'h0) begin
            errors++;
            $display("FAIL reset_counters: load=%h store=%h expected 0 0", load_count, store_count);
        end
        // Aggressive inputs during CLEAR must be ignored.
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 4'h5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clear("reset");
        checks++;
        if ({WB_Data_out, D_out, RegWrite_out, jump_taken, jump_target} !== {32'd0, 4'd0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clear_ignores_inputs: wb=%h d=%h rw=%b jt=%b tgt=%h expected all 0",
                     WB_Data_out, D_out, RegWrite_out, jump_taken, jump_target);
        end
        checks++;
        if (load_count !== 4'h0 || store_count !== 4'h0) begin
            errors++;
            $display("FAIL clear_counters: load=%h store=%h expected 0 0", load_count, store_count);
        end
        drive(1'b1, 32'h1234_5678, 1'b0, 4'h1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'd0) begin
            errors++;
            $display("FAIL load_00_after_clear: got %h expected 00000000", WB_Data_out);
        end
        drive(1'b1, 32'h1234_5678, 1'b0, 4'h1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'd0) begin
            errors++;
            $display("FAIL load_ff_after_clear: got %h expected 00000000", WB_Data_out);
        end
        checks++;
        if (load_count !== cexp(2)) begin
            errors++;
            $display("FAIL load_count_2: got %h expected %h", load_count, cexp(2));
        end
        idle();
    endtask

    task automatic test_store_load();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 4'h0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_wb_alu: got %h expected deadbeef", WB_Data_out);
        end
        checks++;
        if (store_count !== cexp(1)) begin
            errors++;
            $display("FAIL store_count_1: got %h expected %h", store_count, cexp(1));
        end
        drive(1'b1, 32'h0, 1'b0, 4'h3, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if ({WB_Data_out, D_out, RegWrite_out} !== {32'hDEAD_BEEF, 4'h3, 1'b1}) begin
            errors++;
            $display("FAIL load_10: wb=%h d=%h rw=%b expected deadbeef 3 1", WB_Data_out, D_out, RegWrite_out);
        end
        // DataRead without RegInsrc selects the ALU result.
        drive(1'b1, 32'h0000_00AA, 1'b0, 4'h9, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if ({WB_Data_out, D_out, RegWrite_out} !== {32'h0000_00AA, 4'h9, 1'b0}) begin
            errors++;
            $display("FAIL read_no_insrc: wb=%h d=%h rw=%b expected 000000aa 9 0", WB_Data_out, D_out, RegWrite_out);
        end
        checks++;
        if (load_count !== cexp(4)) begin
            errors++;
            $display("FAIL load_count_4: got %h expected %h", load_count, cexp(4));
        end
        idle();
    endtask

    task automatic test_read_write_same_cycle();
        drive(1'b1, 32'h1111_2222, 1'b0, 4'h3, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rw_same_old_data: got %h expected deadbeef", WB_Data_out);
        end
        drive(1'b1, 32'h0, 1'b0, 4'h3, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'h1111_2222) begin
            errors++;
            $display("FAIL rw_same_write_done: got %h expected 11112222", WB_Data_out);
        end
        checks++;
        if (load_count !== cexp(6) || store_count !== cexp(2)) begin
            errors++;
            $display("FAIL counts_6_2: load=%h store=%h expected %h %h", load_count, store_count, cexp(6), cexp(2));
        end
        idle();
    endtask

    task automatic test_stall();
        drive(1'b0, 32'h0000_0005, 1'b1, 4'h7, 8'h20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        cycle();
        checks++;
        if ({WB_Data_out, D_out, RegWrite_out, jump_taken, jump_target} !== {32'h1111_2222, 4'h3, 1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL stall_hold: wb=%h d=%h rw=%b jt=%b tgt=%h expected 11112222 3 1 0 10",
                     WB_Data_out, D_out, RegWrite_out, jump_taken, jump_target);
        end
        checks++;
        if (load_count !== cexp(6) || store_count !== cexp(2)) begin
            errors++;
            $display("FAIL stall_counts: load=%h store=%h expected %h %h", load_count, store_count, cexp(6), cexp(2));
        end
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 4'h2, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'd0) begin
            errors++;
            $display("FAIL stall_no_write: got %h expected 00000000", WB_Data_out);
        end
        idle();
    endtask

    task automatic test_jump();
        drive(1'b1, 32'h1, 1'b1, 4'h0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        checks++;
        if (jump_taken !== 1'b1 || jump_target !== 8'h44) begin
            errors++;
            $display("FAIL jump_taken: jt=%b tgt=%h expected 1 44", jump_taken, jump_target);
        end
        drive(1'b1, 32'h0, 1'b0, 4'h0, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        checks++;
        if (jump_taken !== 1'b0 || jump_target !== 8'h45) begin
            errors++;
            $display("FAIL jump_x0: jt=%b tgt=%h expected 0 45", jump_taken, jump_target);
        end
        drive(1'b1, 32'h1, 1'b1, 4'h0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (jump_taken !== 1'b0 || jump_target !== 8'h46) begin
            errors++;
            $display("FAIL jump_js0: jt=%b tgt=%h expected 0 46", jump_taken, jump_target);
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (100) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy: got %b expected 1", busy);
        end
        wait_clear("mid_clear");
    endtask

    task automatic test_reset_mid_run();
        drive(1'b1, 32'hCAFE_F00D, 1'b0, 4'h0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h0, 1'b0, 4'h0, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL store_30: got %h expected cafef00d", WB_Data_out);
        end
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1 || WB_Data_out !== 32'd0 || load_count !== 4'h0 || store_count !== 4'h0) begin
            errors++;
            $display("FAIL mid_run_reset: busy=%b wb=%h load=%h store=%h expected 1 0 0 0",
                     busy, WB_Data_out, load_count, store_count);
        end
        wait_clear("mid_run");
        drive(1'b1, 32'h5555_5555, 1'b0, 4'h0, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        checks++;
        if (WB_Data_out !== 32'd0) begin
            errors++;
            $display("FAIL mid_run_cleared_30: got %h expected 00000000", WB_Data_out);
        end
        idle();
    endtask

    task automatic test_saturate();
        // One load already counted since the last reset; 20 more gives 21.
        drive(1'b1, 32'h0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (13) cycle();
        checks++;
        if (load_count !== cexp(14)) begin
            errors++;
            $display("FAIL load_count_14: got %h expected %h", load_count, cexp(14));
        end
        repeat (7) cycle();
        idle();
        checks++;
        if (load_count !== cexp(21)) begin
            errors++;
            $display("FAIL load_count_sat: got %h expected %h", load_count, cexp(21));
        end
        checks++;
        if (store_count !== 4'h0) begin
            errors++;
            $display("FAIL store_count_zero: got %h expected 0", store_count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();
        test_reset();
        test_store_load();
        test_read_write_same_cycle();
        test_stall();
        test_jump();
        test_reset_mid_clear();
        test_reset_mid_run();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
